// File: rtl/mario_anim_pkg.sv
// Shared state encoding and frame slot constants for the player sprite animation sequencer.
package mario_anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_AIR  = 2'd2
  } anim_state_e;

  localparam logic [1:0] FRAME_STAND      = 2'd0;
  localparam logic [1:0] FRAME_WALK_FIRST = 2'd1;
  localparam logic [1:0] FRAME_AIR        = 2'd2;

endpackage

// File: rtl/mario_anim_sequencer_vsync_tick_sync.sv
// Brings the asynchronous vertical sync into the Clk domain and emits one Clk-wide
// pulse per rising edge of frame_clk.
module vsync_tick_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic frame_tick
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= frame_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s3 only delays s2 for edge detection; s1 is the metastability stage
  assign frame_tick = s2_q & ~s3_q;

endmodule

// File: rtl/mario_anim_sequencer.sv
// Player sprite frame index sequencer: idle / walk cycle / airborne poses, switched only on
// the synchronized vsync tick. Optional run speed-up enabled by `define MARIO_ANIM_RUN_EN.
module mario_anim_sequencer
  import mario_anim_pkg::*;
#(
  parameter int HOLD_FRAMES = 6,
  parameter int HOLD_W      = 4
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       moving,
  input  logic       airborne,
  input  logic       dir_left,
`ifdef MARIO_ANIM_RUN_EN
  input  logic       run,
`endif
  output logic [1:0] frame_number,
  output logic       facing_left,
  output logic       frame_tick
);

  localparam logic [HOLD_W-1:0] LIM_M1_WALK = HOLD_W'(HOLD_FRAMES - 1);
`ifdef MARIO_ANIM_RUN_EN
  localparam int                RUN_LIMIT   = (HOLD_FRAMES / 2 < 1) ? 1 : HOLD_FRAMES / 2;
  localparam logic [HOLD_W-1:0] LIM_M1_RUN  = HOLD_W'(RUN_LIMIT - 1);
`endif

  anim_state_e       state_q, state_d;
  logic [1:0]        frame_q, frame_d;
  logic [HOLD_W-1:0] hold_q,  hold_d;
  logic              facing_q, facing_d;
  logic [HOLD_W-1:0] lim_m1;

  vsync_tick_sync u_sync (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .frame_tick(frame_tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      frame_q  <= FRAME_STAND;
      hold_q   <= '0;
      facing_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      hold_q   <= hold_d;
      facing_q <= facing_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    facing_d = facing_q;
    lim_m1   = LIM_M1_WALK;
`ifdef MARIO_ANIM_RUN_EN
    if (run) lim_m1 = LIM_M1_RUN;
`endif
    if (frame_tick) begin
      if (moving) facing_d = dir_left;
      case (state_q)
        ST_IDLE: begin
          if (airborne) begin
            state_d = ST_AIR;
            frame_d = FRAME_AIR;
          end else if (moving) begin
            state_d = ST_WALK;
            frame_d = FRAME_WALK_FIRST;
            hold_d  = '0;
          end else begin
            frame_d = FRAME_STAND;
          end
        end
        ST_WALK: begin
          if (airborne) begin
            state_d = ST_AIR;
            frame_d = FRAME_AIR;
            hold_d  = '0;
          end else if (!moving) begin
            state_d = ST_IDLE;
            frame_d = FRAME_STAND;
            hold_d  = '0;
          end else if (hold_q >= lim_m1) begin
            // >= rather than == so a shorter run limit advances at once instead of overflowing
            hold_d  = '0;
            frame_d = frame_q + 2'd1;
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
          end
        end
        ST_AIR: begin
          if (airborne) begin
            frame_d = FRAME_AIR;
          end else if (moving) begin
            state_d = ST_WALK;
            frame_d = FRAME_WALK_FIRST;
            hold_d  = '0;
          end else begin
            state_d = ST_IDLE;
            frame_d = FRAME_STAND;
          end
        end
        default: begin
          state_d = ST_IDLE;
          frame_d = FRAME_STAND;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign frame_number = frame_q;
  assign facing_left  = facing_q;

endmodule
